pow_dispatch: RTL and testbench
===============================

Name: pow_dispatch

Overview:
- Request front-end for the 16-bit iterative power unit (x^n, start/ready handshake).
- Buffers (x, n) requests in a FIFO and issues them to the power unit one at a time.
- Captures each finished result and presents it downstream with a valid/ack handshake and a sequence tag.
- Sits between the request source and the power unit, and between the power unit and the result consumer.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, at least 2.
- TAGW, 8, width of the sequence tag; wraps modulo 2^TAGW.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request offered
- in_ready  out  1  FIFO can accept; equals !full
- in_x  in  16  base
- in_n  in  8  exponent
- pw_start  out  1  one-cycle start pulse to power unit
- pw_x  out  16  base to power unit, registered
- pw_n  out  8  exponent to power unit, registered
- pw_ready  in  1  power unit ready (1 = idle/done, 0 = busy)
- pw_out  in  16  power unit result
- res_valid  out  1  result available
- res_ack  in  1  consumer takes result
- res_data  out  16  result x^n mod 2^16
- res_tag  out  TAGW  sequence number of the request

Behaviour:
- Reset (async, rst=1): FIFO empty, state IDLE, tag counter 0. Outputs: in_ready=1, pw_start=0, pw_x=0, pw_n=0, res_valid=0, res_data=0, res_tag=0.
- Reset mid-operation: any in-flight request and any buffered requests are discarded; no result is emitted for them.
- FIFO push: occurs on a clock edge when in_valid & in_ready.
- Full FIFO: in_ready=0; a push in the same cycle as a pop is refused (in_ready is never combinationally dependent on pop).
- Tags: each accepted request is tagged with the tag counter value, then the counter increments (wraps at 2^TAGW). The tag is stored in the FIFO alongside x and n.
- State machine:
  - IDLE: if FIFO non-empty and pw_ready=1, go to ISSUE.
  - ISSUE (1 cycle): pop the head; load pw_x, pw_n and the tag register; pw_start=1 for this cycle only. Next state is WAIT_BUSY.
  - WAIT_BUSY: wait for pw_ready=0, then go to WAIT_DONE. The power unit drops ready the edge after start, so this state normally lasts 1 cycle.
  - WAIT_DONE: when pw_ready=1, capture pw_out into res_data and the tag into res_tag, set res_valid=1, and go to HOLD.
  - HOLD: res_valid, res_data and res_tag are held stable until res_ack=1. On the ack edge, res_valid=0 and the state goes to IDLE.
- Ordering: results are delivered strictly in acceptance order; at most one request is in flight.
- pw_x and pw_n: stable from ISSUE until the next ISSUE.
- Throughput: minimum 4 cycles of overhead plus power-unit run time per request.
- Exponent n=0: the power unit returns 1 after one busy cycle; no special case is needed.
- Width: the result is the low 16 bits of x^n; overflow is silently truncated.
- pw_start is never asserted outside ISSUE.

Optional Feature:
- Macro: POW_DISPATCH_BYPASS_EN.
- Defined: in IDLE, if the FIFO head has n=0 or n=1, the block pops it and moves directly to HOLD without engaging the power unit.
  - res_data is 16'h0001 for n=0 and x for n=1.
  - pw_start stays 0 for that request.
  - res_valid is asserted the cycle after the pop.
  - Tags and ordering are unchanged.
  - The bypass applies even when pw_ready=0.
- Undefined: all requests go through the power unit.

Test Plan:
- Push x=3, n=4; res_ack held 1 -> exactly one pw_start pulse with pw_x=3, pw_n=4; res_valid with res_data=81, res_tag=0.
- Push x=16'h0100, n=2 -> res_data=16'h0000 (truncation); then push x=2, n=0 -> res_data=1, tag=1. With POW_DISPATCH_BYPASS_EN, the second request produces no pw_start.
- DEPTH=4, res_ack=0, push 6 back-to-back -> 5 accepted (1 in flight, 4 buffered) and in_ready=0. Acking one at a time then yields tags 0..4 in order with correct results.
- Hold res_ack=0 for 10 cycles after res_valid -> res_data and res_tag stable and no new pw_start; after ack, the next issue occurs within 2 cycles.
- Assert rst during WAIT_DONE with 2 requests queued -> all outputs return to reset values immediately; after release, no result is emitted and in_ready=1.
- Issue 257 requests -> tags wrap 255 -> 0 -> 0 for the 257th result.

Source files
------------

// File: rtl/pow_dispatch.sv
// Request FIFO and sequencer in front of the 16-bit iterative power unit (x^n).
// Define POW_DISPATCH_BYPASS_EN to resolve n=0 / n=1 requests without the power unit.
module pow_dispatch #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAGW  = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [15:0]     in_x,
   input  logic [7:0]      in_n,
   output logic            pw_start,
   output logic [15:0]     pw_x,
   output logic [7:0]      pw_n,
   input  logic            pw_ready,
   input  logic [15:0]     pw_out,
   output logic            res_valid,
   input  logic            res_ack,
   output logic [15:0]     res_data,
   output logic [TAGW-1:0] res_tag
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PtrOne = 1;
   localparam logic [TAGW-1:0] TagOne = 1;

   typedef enum logic [2:0] {StIdle, StIssue, StWaitBusy, StWaitDone, StHold} state_e;

   state_e          state_q;
   logic [15:0]     fifo_x   [DEPTH];
   logic [7:0]      fifo_n   [DEPTH];
   logic [TAGW-1:0] fifo_tag [DEPTH];
   logic [AW:0]     wptr_q, rptr_q;
   logic [TAGW-1:0] tag_cnt_q, tag_q;
   logic            full, empty, push, pop, issue, bypass;
   logic [15:0]     head_x;
   logic [7:0]      head_n;
   logic [TAGW-1:0] head_tag;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty    = (wptr_q == rptr_q);
   assign in_ready = !full;
   assign push     = in_valid && !full;

   assign head_x   = fifo_x[rptr_q[AW-1:0]];
   assign head_n   = fifo_n[rptr_q[AW-1:0]];
   assign head_tag = fifo_tag[rptr_q[AW-1:0]];

`ifdef POW_DISPATCH_BYPASS_EN
   assign bypass = (state_q == StIdle) && !empty && (head_n <= 8'd1);
`else
   assign bypass = 1'b0;
`endif
   assign issue = (state_q == StIdle) && !empty && pw_ready && !bypass;
   assign pop   = issue || bypass;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_x[wptr_q[AW-1:0]]   <= in_x;
         fifo_n[wptr_q[AW-1:0]]   <= in_n;
         fifo_tag[wptr_q[AW-1:0]] <= tag_cnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         wptr_q    <= '0;
         rptr_q    <= '0;
         tag_cnt_q <= '0;
         tag_q     <= '0;
         pw_start  <= 1'b0;
         pw_x      <= '0;
         pw_n      <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_tag   <= '0;
      end else begin
         pw_start <= 1'b0;
         if (push) begin
            wptr_q    <= wptr_q + PtrOne;
            tag_cnt_q <= tag_cnt_q + TagOne;
         end
         if (pop) begin
            rptr_q <= rptr_q + PtrOne;
         end
         case (state_q)
            StIdle: begin
               if (bypass) begin
                  res_valid <= 1'b1;
                  res_data  <= (head_n == 8'd0) ? 16'h0001 : head_x;
                  res_tag   <= head_tag;
                  state_q   <= StHold;
               end else if (issue) begin
                  // Head is popped on entry so pw_x/pw_n line up with the start pulse.
                  pw_start <= 1'b1;
                  pw_x     <= head_x;
                  pw_n     <= head_n;
                  tag_q    <= head_tag;
                  state_q  <= StIssue;
               end
            end
            StIssue: state_q <= StWaitBusy;
            StWaitBusy: begin
               if (!pw_ready) begin
                  state_q <= StWaitDone;
               end
            end
            StWaitDone: begin
               if (pw_ready) begin
                  res_valid <= 1'b1;
                  res_data  <= pw_out;
                  res_tag   <= tag_q;
                  state_q   <= StHold;
               end
            end
            StHold: begin
               if (res_ack) begin
                  res_valid <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_pow_dispatch.sv
// Randomised and directed bench for pow_dispatch with a power-unit model and a
// request-order reference model.
module tb_pow_dispatch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_x = '0;
   logic [7:0]  in_n = '0;
   logic        pw_start;
   logic [15:0] pw_x;
   logic [7:0]  pw_n;
   logic        pw_ready;
   logic [15:0] pw_out;
   logic        res_valid;
   logic        res_ack = 1'b0;
   logic [15:0] res_data;
   logic [7:0]  res_tag;

   int checks = 0;
   int errors = 0;

   pow_dispatch #(.DEPTH(4), .TAGW(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_n(in_n),
      .pw_start(pw_start), .pw_x(pw_x), .pw_n(pw_n), .pw_ready(pw_ready), .pw_out(pw_out),
      .res_valid(res_valid), .res_ack(res_ack), .res_data(res_data), .res_tag(res_tag)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] powf(input logic [15:0] x, input logic [7:0] n);
      logic [15:0] r;
      r = 16'd1;
      for (int i = 0; i < int'(n); i++) r = r * x;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Power unit model: ready drops the edge after start, busy for (n%8)+1 cycles.
   logic        pu_ready;
   logic [15:0] pu_res;
   int          pu_cnt;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pu_ready <= 1'b1;
         pu_cnt   <= 0;
         pu_res   <= '0;
      end else if (pu_ready) begin
         if (pw_start) begin
            pu_ready <= 1'b0;
            pu_cnt   <= int'(pw_n % 8'd8);
            pu_res   <= powf(pw_x, pw_n);
         end
      end else if (pu_cnt == 0) begin
         pu_ready <= 1'b1;
      end else begin
         pu_cnt <= pu_cnt - 1;
      end
   end
   assign pw_ready = pu_ready;
   assign pw_out   = pu_res;

   // Reference model: accepted requests in order; result k must be x_k^n_k tagged k mod 256.
   logic [15:0] acc_x [0:4095];
   logic [7:0]  acc_n [0:4095];
   int          nacc = 0;
   int          delivered = 0;
   int          nstarts = 0;
   int          nvalid = 0;
   logic [7:0]  last_tag = '0;
   logic        prev_v = 1'b0, prev_ack = 1'b0, prev_start = 1'b0;
   logic [15:0] prev_data = '0;
   logic [7:0]  prev_tag = '0;

   always @(negedge clk) begin
      if (rst) begin
         nacc      = 0;
         delivered = 0;
         prev_v    = 1'b0;
         prev_ack  = 1'b0;
         prev_start = 1'b0;
      end else begin
         if (pw_start) begin
            nstarts++;
            chk("pw_start while result held", 32'(res_valid), 32'd0);
            chk("pw_start longer than one cycle", 32'(prev_start), 32'd0);
            chk("pw_start with nothing queued", 32'(delivered < nacc), 32'd1);
            if (delivered < nacc) begin
               chk("pw_x", 32'(pw_x), 32'(acc_x[delivered]));
               chk("pw_n", 32'(pw_n), 32'(acc_n[delivered]));
`ifdef POW_DISPATCH_BYPASS_EN
               chk("bypassable request issued", 32'(acc_n[delivered] > 8'd1), 32'd1);
`endif
            end
         end
         if (res_valid) begin
            nvalid++;
            last_tag = res_tag;
            if (delivered < nacc) begin
               chk("res_data", 32'(res_data), 32'(powf(acc_x[delivered], acc_n[delivered])));
               chk("res_tag", 32'(res_tag), 32'(delivered % 256));
            end else begin
               chk("res_valid with no pending request", 32'(res_valid), 32'd0);
            end
            if (prev_v && !prev_ack) begin
               chk("res_data stable in hold", 32'(res_data), 32'(prev_data));
               chk("res_tag stable in hold", 32'(res_tag), 32'(prev_tag));
            end
            if (res_ack) delivered++;
         end else if (prev_v && !prev_ack) begin
            chk("res_valid dropped without ack", 32'(res_valid), 32'd1);
         end
         if (in_valid && in_ready && nacc < 4096) begin
            acc_x[nacc] = in_x;
            acc_n[nacc] = in_n;
            nacc++;
         end
         prev_v     = res_valid;
         prev_ack   = res_ack;
         prev_start = pw_start;
         prev_data  = res_data;
         prev_tag   = res_tag;
      end
   end

   // Call with inputs phase-aligned just after a rising edge; returns likewise.
   task automatic push(input logic [15:0] x, input logic [7:0] n);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_x = x;
      in_n = n;
      @(negedge clk);
      while (!in_ready && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk("push accepted in time", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_res();
      int t;
      t = 0;
      @(negedge clk);
      while (!res_valid && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (!res_valid) chk("result arrives in time", 32'(res_valid), 32'd1);
   endtask

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      @(negedge clk);
      while (!(delivered == nacc && !res_valid) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      chk("drain completes", 32'(delivered), 32'(nacc));
      align();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      res_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   int s0, v0, found;

   initial begin
      #1;
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset res_valid", 32'(res_valid), 32'd0);
      chk("reset pw_start", 32'(pw_start), 32'd0);
      do_reset();

      // 3^4 through the power unit.
      res_ack = 1'b1;
      s0 = nstarts;
      push(16'd3, 8'd4);
      wait_res();
      chk("3^4 data", 32'(res_data), 32'd81);
      chk("3^4 tag", 32'(res_tag), 32'd0);
      wait_drain();
      chk("3^4 single start", 32'(nstarts - s0), 32'd1);
      chk("3^4 pw_x held", 32'(pw_x), 32'd3);
      chk("3^4 pw_n held", 32'(pw_n), 32'd4);

      // Truncation, then n=0.
      do_reset();
      res_ack = 1'b1;
      s0 = nstarts;
      push(16'h0100, 8'd2);
      wait_res();
      chk("0x100^2 truncated", 32'(res_data), 32'd0);
      align();
      push(16'd2, 8'd0);
      wait_res();
      chk("2^0 data", 32'(res_data), 32'd1);
      chk("2^0 tag", 32'(res_tag), 32'd1);
      wait_drain();
`ifdef POW_DISPATCH_BYPASS_EN
      chk("n=0 bypasses power unit", 32'(nstarts - s0), 32'd1);
`else
      chk("n=0 uses power unit", 32'(nstarts - s0), 32'd2);
`endif

      // Fill: six offers with no ack -> five accepted.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_x = 16'($urandom);
         in_n = 8'($urandom_range(2, 15));
         align();
      end
      in_valid = 1'b0;
      chk("accepted when full", 32'(nacc), 32'd5);
      chk("in_ready low when full", 32'(in_ready), 32'd0);
      for (int i = 0; i < 5; i++) begin
         wait_res();
         chk("in-order tag", 32'(res_tag), 32'(i));
         align();
         res_ack = 1'b1;
         align();
         res_ack = 1'b0;
      end
      res_ack = 1'b1;
      wait_drain();

      // Long hold, then prompt reissue after ack.
      do_reset();
      s0 = nstarts;
      push(16'd5, 8'd3);
      push(16'd7, 8'd2);
      wait_res();
      repeat (10) @(negedge clk);
      chk("hold res_valid", 32'(res_valid), 32'd1);
      chk("hold res_data", 32'(res_data), 32'd125);
      chk("hold res_tag", 32'(res_tag), 32'd0);
      chk("no issue during hold", 32'(nstarts - s0), 32'd1);
      align();
      res_ack = 1'b1;
      align();
      res_ack = 1'b0;
      found = 0;
      for (int t = 0; t < 2 && found == 0; t++) begin
         @(negedge clk);
         if (pw_start) found = 1;
      end
      chk("issue within 2 cycles of ack", 32'(found), 32'd1);
      res_ack = 1'b1;
      wait_drain();

      // Reset while waiting on the power unit with two requests queued.
      do_reset();
      res_ack = 1'b1;
      s0 = nstarts;
      push(16'd3, 8'd7);
      push(16'd4, 8'd7);
      push(16'd5, 8'd7);
      chk("first issued before reset", 32'(nstarts - s0), 32'd1);
      repeat (2) @(negedge clk);
      chk("still waiting before reset", 32'(res_valid), 32'd0);
      align();
      rst = 1'b1;
      #1;
      chk("async reset in_ready", 32'(in_ready), 32'd1);
      chk("async reset pw_start", 32'(pw_start), 32'd0);
      chk("async reset pw_x", 32'(pw_x), 32'd0);
      chk("async reset pw_n", 32'(pw_n), 32'd0);
      chk("async reset res_valid", 32'(res_valid), 32'd0);
      chk("async reset res_data", 32'(res_data), 32'd0);
      chk("async reset res_tag", 32'(res_tag), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      v0 = nvalid;
      repeat (30) @(negedge clk);
      chk("no result after reset", 32'(nvalid - v0), 32'd0);
      chk("in_ready after reset", 32'(in_ready), 32'd1);
      align();

      // Random traffic with random backpressure.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         in_valid = 1'($urandom);
         in_x = 16'($urandom);
         in_n = 8'($urandom_range(0, 15));
         res_ack = ($urandom_range(0, 2) != 0);
         align();
      end
      in_valid = 1'b0;
      res_ack = 1'b1;
      wait_drain();
      chk("random traffic produced results", 32'(delivered > 20), 32'd1);

      // Tag wrap over 257 requests.
      do_reset();
      res_ack = 1'b1;
      for (int i = 0; i < 257; i++) push(16'($urandom), 8'($urandom_range(0, 255)));
      wait_drain();
      chk("257 results delivered", 32'(delivered), 32'd257);
      chk("257th tag wraps to 0", 32'(last_tag), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
